// File: rtl/demux_1_to_4_stream_pkg.sv
// Shared definitions for the 1-to-4 packet-aware stream demultiplexer.
//   state_e     : packet FSM states (IDLE between packets, BUSY inside one)
//   CH0..CH3    : channel indices
//   sel_to_ch() : select-line decode, same encoding as the 4-to-1 mux
package demux_1_to_4_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int unsigned NUM_CH = 4;

  localparam logic [1:0] CH0 = 2'd0;
  localparam logic [1:0] CH1 = 2'd1;
  localparam logic [1:0] CH2 = 2'd2;
  localparam logic [1:0] CH3 = 2'd3;

  // {s0,s1}: 00->ch0, 01->ch1, 10->ch2, 11->ch3
  function automatic logic [1:0] sel_to_ch(input logic s0, input logic s1);
    return {s0, s1};
  endfunction

endpackage

// File: rtl/demux_1_to_4_stream_slot.sv
// demux_slot: one-entry registered output buffer for a single channel.
//   clk, rst_n          : clock, synchronous active-low reset
//   load                : accept a new beat this cycle
//   in_data, in_last    : beat to load
//   out_ready           : downstream ready
//   out_data, out_last,
//   out_valid           : registered channel outputs
module demux_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_valid
);

  // A load wins over a drain, so a slot that empties and refills in the
  // same cycle stays valid holding the new beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= in_data;
      out_last  <= in_last;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1_to_4_stream.sv
// demux_1_to_4_stream: steers one valid/ready stream to one of four
// registered channels. The select is locked at a packet's first beat and
// held until its last beat; each channel counts completed packets.
//   clk, rst_n                       : clock, synchronous active-low reset
//   in_data/in_valid/in_last/in_ready: input stream
//   s0, s1                           : channel select (sampled at packet start)
//   out_data/out_valid/out_last/
//   out_ready                        : four output channels, ch0 in the LSBs
//   pkt_cnt                          : per-channel completed-packet counters
//   busy                             : a multi-beat packet is in progress
module demux_1_to_4_stream
  import demux_1_to_4_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  input  logic               s0,
  input  logic               s1,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  output logic [3:0]         out_last,
  input  logic [3:0]         out_ready,
  output logic [4*CNT_W-1:0] pkt_cnt,
  output logic               busy
);

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] tgt;
  logic       accept;
  logic [CNT_W-1:0] cnt_q [NUM_CH];

  // Live select while idle, locked select inside a packet.
  assign tgt      = (state_q == BUSY) ? sel_q : sel_to_ch(s0, s1);
  assign in_ready = !out_valid[tgt] || out_ready[tgt];
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == BUSY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= CH0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (accept) begin
      unique case (state_q)
        IDLE: if (!in_last) begin
          state_d = BUSY;
          sel_d   = sel_to_ch(s0, s1);
        end
        BUSY: if (in_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else if (accept && in_last) begin
      for (int unsigned i = 0; i < NUM_CH; i++)
        if (tgt == 2'(i)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_ch
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept && (tgt == 2'(k))),
      .in_data  (in_data),
      .in_last  (in_last),
      .out_ready(out_ready[k]),
      .out_data (out_data[k*WIDTH +: WIDTH]),
      .out_last (out_last[k]),
      .out_valid(out_valid[k])
    );
    assign pkt_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
  end

endmodule

// File: tb/tb_demux_1_to_4_stream.sv
// Self-checking bench for demux_1_to_4_stream: directed table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_demux_1_to_4_stream;

  localparam int W  = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, in_last, in_ready, s0, s1, busy;
  logic [W-1:0]  in_data;
  logic [4*W-1:0] out_data;
  logic [3:0]    out_valid, out_last, out_ready;
  logic [4*CW-1:0] pkt_cnt;

  demux_1_to_4_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .s0(s0), .s1(s1),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .pkt_cnt(pkt_cnt), .busy(busy)
  );

  int unsigned n_chk = 0, n_pass = 0;

  // Model: each channel is a queue of {last,data} beats (depth 0 or 1).
  logic [8:0]    q [4][$];
  logic [CW-1:0] mcnt [4];
  logic          mbusy = 1'b0;
  logic [1:0]    mlock = 2'd0;
  logic          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      mcnt[k] = '0;
    end
    mbusy = 1'b0;
    mlock = 2'd0;
  endtask

  // Drive one cycle, compare the pre-edge DUT state with the model, then
  // advance the model across the edge.
  task automatic cycle(input logic r, input logic v, input logic [7:0] d, input logic l,
                       input logic [1:0] s, input logic [3:0] ordy, output logic acc);
    logic [1:0] t;
    logic       rdy;
    rst_n = r; in_valid = v; in_data = d; in_last = l; {s0, s1} = s; out_ready = ordy;
    #1;
    t   = mbusy ? mlock : s;
    rdy = (q[t].size() == 0) || ordy[t];
    acc = r && v && rdy;
    if (chk_en) begin
      check("in_ready", in_ready, rdy);
      check("busy", busy, mbusy);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("out_valid[%0d]", k), out_valid[k], q[k].size() != 0);
        if (q[k].size() != 0) begin
          check($sformatf("out_data[%0d]", k), out_data[k*W +: W], q[k][0][7:0]);
          check($sformatf("out_last[%0d]", k), out_last[k], q[k][0][8]);
        end
        check($sformatf("pkt_cnt[%0d]", k), pkt_cnt[k*CW +: CW], mcnt[k]);
      end
    end
    if (!r) begin
      model_reset();
    end else begin
      for (int k = 0; k < 4; k++)
        if (q[k].size() != 0 && ordy[k]) void'(q[k].pop_front());
      if (acc) begin
        q[t].push_back({l, d});
        if (l) begin
          mcnt[t] = mcnt[t] + 1'b1;
          mbusy   = 1'b0;
        end else if (!mbusy) begin
          mbusy = 1'b1;
          mlock = s;
        end
      end
    end
    @(posedge clk);
    #1;
    chk_en = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic [1:0] s, input logic [3:0] ordy);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 16 && !acc; i++) cycle(1'b1, 1'b1, d, l, s, ordy, acc);
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic       vld;
    logic [7:0] d;
    logic       lst;
    logic [1:0] s;
    logic [3:0] exp_ov;
    logic       exp_busy;
    logic [1:0] ch;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic acc;
    logic [CW-1:0] saved;
    model_reset();

    // Routing of single-beat packets, then a locked 3-beat packet to ch2.
    tbl[0] = '{1'b1, 8'hA0, 1'b1, 2'b00, 4'b0001, 1'b0, 2'd0};
    tbl[1] = '{1'b1, 8'hA1, 1'b1, 2'b01, 4'b0010, 1'b0, 2'd1};
    tbl[2] = '{1'b1, 8'hA2, 1'b1, 2'b10, 4'b0100, 1'b0, 2'd2};
    tbl[3] = '{1'b1, 8'hA3, 1'b1, 2'b11, 4'b1000, 1'b0, 2'd3};
    tbl[4] = '{1'b1, 8'h11, 1'b0, 2'b10, 4'b0100, 1'b1, 2'd2};
    tbl[5] = '{1'b1, 8'h22, 1'b0, 2'b01, 4'b0100, 1'b1, 2'd2};
    tbl[6] = '{1'b1, 8'h33, 1'b1, 2'b01, 4'b0100, 1'b0, 2'd2};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 2'b00, 4'b0000, 1'b0, 2'd2};

    // Reset held two cycles with a beat offered.
    cycle(1'b0, 1'b1, 8'hEE, 1'b1, 2'b00, 4'b1111, acc);
    cycle(1'b0, 1'b1, 8'hEE, 1'b1, 2'b01, 4'b1111, acc);
    check("reset_out_valid", out_valid, 4'b0000);
    check("reset_pkt_cnt", pkt_cnt, 32'd0);
    check("reset_busy", busy, 1'b0);

    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, tbl[i].vld, tbl[i].d, tbl[i].lst, tbl[i].s, 4'b1111, acc);
      check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].exp_ov);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
      if (tbl[i].exp_ov[tbl[i].ch])
        check($sformatf("tbl%0d_data", i), out_data[tbl[i].ch*W +: W], tbl[i].d);
    end
    check("route_pkt_cnt", pkt_cnt, {8'd1, 8'd2, 8'd1, 8'd1});

    // Backpressure: ch3 stuck holding a beat, ch1 blocked then released.
    cycle(1'b1, 1'b1, 8'hC3, 1'b1, 2'b11, 4'b0111, acc);
    cycle(1'b1, 1'b1, 8'hB1, 1'b0, 2'b01, 4'b0101, acc);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 8'hB2, 1'b0, 2'b10, 4'b0101, acc);
      check("bp_in_ready", in_ready, 1'b0);
    end
    send(8'hB2, 1'b0, 2'b10, 4'b0111);
    send(8'hB3, 1'b1, 2'b10, 4'b0111);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 4'b0111, acc);
    check("bp_ch3_held", out_valid[3], 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 4'b1111, acc);

    // Back-to-back stream to ch0 with simultaneous drain and load.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 8'(8'h40 + i), i == 7, 2'b00, 4'b1111, acc);
      check("stream_out_valid0", out_valid[0], 1'b1);
      check("stream_data0", out_data[7:0], 8'(8'h40 + i));
    end
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 4'b1111, acc);

    // Counter wrap on ch3.
    saved = mcnt[3];
    for (int i = 0; i < 256; i++) cycle(1'b1, 1'b1, 8'(i), 1'b1, 2'b11, 4'b1111, acc);
    check("wrap_pkt_cnt3", pkt_cnt[3*CW +: CW], saved);

    // Reset mid-packet, then a fresh packet start routed to ch0.
    cycle(1'b1, 1'b1, 8'h61, 1'b0, 2'b01, 4'b1111, acc);
    cycle(1'b1, 1'b1, 8'h62, 1'b0, 2'b01, 4'b1111, acc);
    cycle(1'b0, 1'b1, 8'h63, 1'b0, 2'b01, 4'b1111, acc);
    cycle(1'b1, 1'b1, 8'h55, 1'b1, 2'b00, 4'b1111, acc);
    check("midrst_out_valid", out_valid, 4'b0001);
    check("midrst_data0", out_data[7:0], 8'h55);
    check("midrst_busy", busy, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(63) != 0), $urandom_range(1), 8'($urandom),
            ($urandom_range(3) == 0), 2'($urandom), 4'($urandom), acc);
    end
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 4'b1111, acc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
